// File: rtl/banked_scratch_pad_rmw_pkg.sv
// Shared types and helpers for the banked scratch pad with atomic fetch-and-add.
package banked_scratch_pad_rmw_pkg;

    typedef enum logic [1:0] {
        OP_RD  = 2'd0,
        OP_WR  = 2'd1,
        OP_ADD = 2'd2
    } op_t;

    // Floor of log2; callers add one to get the width needed to hold value.
    function automatic int log2(input int value);
        int result;
        int v;
        result = 0;
        v = value;
        while (v > 1) begin
            v = v >> 1;
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/banked_scratch_pad_rmw_rr_arbiter.sv
// Rotating-priority arbiter: the search starts at ptr and the first requester wins.
module banked_scratch_pad_rmw_rr_arbiter #(
    parameter int PORTS     = 8,
    parameter int PORT_BITS = 3
) (
    input  logic [0:PORTS-1]     req,
    input  logic [PORT_BITS-1:0] ptr,
    output logic [0:PORTS-1]     grant,
    output logic [PORT_BITS-1:0] next_ptr
);

    logic found;
    int   idx;

    // Pointer only moves past a winner, so an idle bank keeps its priority order.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < PORTS; i++) begin
            idx = (int'(ptr) + i) % PORTS;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                next_ptr   = PORT_BITS'((idx + 1) % PORTS);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/banked_scratch_pad_rmw.sv
// Multi-port banked scratch pad with per-bank rotating arbitration and fetch-and-add.
// Fixed pipeline: accept -> grant/RAM access -> data register -> response register.
module banked_scratch_pad_rmw
    import banked_scratch_pad_rmw_pkg::*;
#(
    parameter int PORTS      = 8,
    parameter int WIDTH      = 64,
    parameter int BANKS      = 8,
    parameter int BANK_DEPTH = 512,
    parameter int BANK_BITS  = log2(BANKS - 1) + 1,
    parameter int ADDR_WIDTH = log2(BANKS * BANK_DEPTH - 1) + 1,
    parameter int PORT_BITS  = log2(PORTS - 1) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [0:PORTS-1]            rd_en,
    input  logic [0:PORTS-1]            wr_en,
    input  logic [0:PORTS-1]            add_en,
    input  logic [ADDR_WIDTH*PORTS-1:0] addr,
    input  logic [WIDTH*PORTS-1:0]      d,
    output logic [0:PORTS-1]            full,
    output logic [0:PORTS-1]            valid,
    output logic [WIDTH*PORTS-1:0]      q
);

    localparam int ROW_BITS = ADDR_WIDTH - BANK_BITS;

    // Hold stage
    op_t                  hold_op   [PORTS];
    logic [BANK_BITS-1:0] hold_bank [PORTS];
    logic [ROW_BITS-1:0]  hold_row  [PORTS];
    logic [WIDTH-1:0]     hold_data [PORTS];
    logic [0:PORTS-1]     hold_valid;
    logic [0:PORTS-1]     port_grant;

    // Arbitration
    logic [0:PORTS-1]     bank_req    [BANKS];
    logic [0:PORTS-1]     bank_grant  [BANKS];
    logic [PORT_BITS-1:0] ptr         [BANKS];
    logic [PORT_BITS-1:0] next_ptr    [BANKS];
    logic [BANKS-1:0]     bank_any;
    logic [PORT_BITS-1:0] bank_winner [BANKS];
    op_t                  sel_op      [BANKS];
    logic [ROW_BITS-1:0]  sel_row     [BANKS];
    logic [WIDTH-1:0]     sel_data    [BANKS];

    // Bank and response stages
    logic [BANKS-1:0]     wb_pending;
    logic [ROW_BITS-1:0]  wb_row    [BANKS];
    logic [WIDTH-1:0]     wb_addend [BANKS];
    logic [BANKS-1:0]     s1_valid;
    logic [PORT_BITS-1:0] s1_tag    [BANKS];
    logic [BANKS-1:0]     s2_valid;
    logic [PORT_BITS-1:0] s2_tag    [BANKS];
    logic [WIDTH-1:0]     s2_data   [BANKS];
    logic [WIDTH-1:0]     bank_q    [BANKS];
    logic [WIDTH-1:0]     resp_q    [PORTS];

    always_comb begin
        port_grant = '0;
        for (int b = 0; b < BANKS; b++) begin
            port_grant = port_grant | bank_grant[b];
        end
    end

    // A granted port frees its holding register this cycle, so it can refill without a bubble.
    always_comb begin
        full = '0;
        for (int p = 0; p < PORTS; p++) begin
            full[p] = hold_valid[p] & ~port_grant[p];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= '0;
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                if (!full[p]) begin
                    hold_valid[p] <= rd_en[p] | wr_en[p] | add_en[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < PORTS; p++) begin
            if (!full[p] && (rd_en[p] || wr_en[p] || add_en[p])) begin
                hold_op[p]   <= add_en[p] ? OP_ADD : (wr_en[p] ? OP_WR : OP_RD);
                hold_bank[p] <= addr[p*ADDR_WIDTH +: BANK_BITS];
                hold_row[p]  <= addr[p*ADDR_WIDTH+BANK_BITS +: ROW_BITS];
                hold_data[p] <= d[p*WIDTH +: WIDTH];
            end
        end
    end

    // A bank with an add write-back pending is locked out of arbitration for that cycle.
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            bank_req[b] = '0;
            for (int p = 0; p < PORTS; p++) begin
                bank_req[b][p] = hold_valid[p] && (hold_bank[p] == BANK_BITS'(b)) && !wb_pending[b];
            end
        end
    end

    always_comb begin
        bank_any = '0;
        for (int b = 0; b < BANKS; b++) begin
            bank_winner[b] = '0;
            for (int p = 0; p < PORTS; p++) begin
                if (bank_grant[b][p]) begin
                    bank_any[b]    = 1'b1;
                    bank_winner[b] = PORT_BITS'(p);
                end
            end
            sel_op[b]   = hold_op[bank_winner[b]];
            sel_row[b]  = hold_row[bank_winner[b]];
            sel_data[b] = hold_data[bank_winner[b]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_pending <= '0;
            s1_valid   <= '0;
            s2_valid   <= '0;
            for (int b = 0; b < BANKS; b++) begin
                ptr[b] <= '0;
            end
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                ptr[b]        <= next_ptr[b];
                wb_pending[b] <= bank_any[b] && (sel_op[b] == OP_ADD);
                s1_valid[b]   <= bank_any[b] && (sel_op[b] != OP_WR);
                s2_valid[b]   <= s1_valid[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < BANKS; b++) begin
            if (bank_any[b]) begin
                s1_tag[b]    <= bank_winner[b];
                wb_row[b]    <= sel_row[b];
                wb_addend[b] <= sel_data[b];
            end
            s2_tag[b]  <= s1_tag[b];
            s2_data[b] <= bank_q[b];
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [WIDTH-1:0] mem [BANK_DEPTH];
        logic [WIDTH-1:0] ram_q;

        banked_scratch_pad_rmw_rr_arbiter #(
            .PORTS     (PORTS),
            .PORT_BITS (PORT_BITS)
        ) u_arb (
            .req      (bank_req[b]),
            .ptr      (ptr[b]),
            .grant    (bank_grant[b]),
            .next_ptr (next_ptr[b])
        );

        // ram_q still holds the pre-add value during the locked cycle, so the sum is formed from it.
        always_ff @(posedge clk) begin
            if (!rst) begin
                if (wb_pending[b]) begin
                    mem[wb_row[b]] <= ram_q + wb_addend[b];
                end else if (bank_any[b] && (sel_op[b] == OP_WR)) begin
                    mem[sel_row[b]] <= sel_data[b];
                end
            end
            if (bank_any[b]) begin
                ram_q <= mem[sel_row[b]];
            end
        end

        assign bank_q[b] = ram_q;
    end

    // Each port is granted at most once per cycle, so at most one bank targets a port here.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            for (int p = 0; p < PORTS; p++) begin
                resp_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                valid[p] <= 1'b0;
                for (int b = 0; b < BANKS; b++) begin
                    if (s2_valid[b] && (s2_tag[b] == PORT_BITS'(p))) begin
                        valid[p]  <= 1'b1;
                        resp_q[p] <= s2_data[b];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_q
        assign q[p*WIDTH +: WIDTH] = resp_q[p];
    end

endmodule

// File: doc/banked_scratch_pad_rmw.md
Name: banked_scratch_pad_rmw

Overview:
- Multi-port banked scratch pad, successor to the omega-network scratch pad.
- Decouples port count from bank count (BANKS independent of PORTS).
- Uses per-bank rotating-priority arbitration instead of round-robin routing, and adds an atomic fetch-and-add mode alongside read and write.
- Fixed pipeline latency per granted request, so responses return in order per port and no reorder queue is needed. Sits between compute engines and on-chip SRAM.

Parameters:
- PORTS, 8, number of requester ports.
- WIDTH, 64, data word width.
- BANKS, 8, number of RAM banks; power of two, at least 2.
- BANK_DEPTH, 512, words per bank.
- BANK_BITS, log2(BANKS-1)+1, bank select width (derived).
- ADDR_WIDTH, log2(BANKS*BANK_DEPTH-1)+1, word address width (derived).
- PORT_BITS, log2(PORTS-1)+1, port index width (derived).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous and active-high.
- rd_en  input  [0:PORTS-1]  read request per port.
- wr_en  input  [0:PORTS-1]  write request per port.
- add_en  input  [0:PORTS-1]  atomic fetch-and-add request per port.
- addr  input  ADDR_WIDTH*PORTS  word address; port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- d  input  WIDTH*PORTS  write data or addend; port p at [p*WIDTH +: WIDTH].
- full  output  [0:PORTS-1]  port may not issue a request this cycle.
- valid  output  [0:PORTS-1]  response on q is valid this cycle.
- q  output  WIDTH*PORTS  read data, or pre-add value for adds; port p at [p*WIDTH +: WIDTH].

Behaviour:
- Address mapping: bank = addr[BANK_BITS-1:0]; row = addr[ADDR_WIDTH-1:BANK_BITS].
- Opcode per port: add_en has priority over wr_en, which has priority over rd_en. Multiple enables high in one cycle are legal; only the highest-priority one is performed.
- Hold stage:
  - One holding register per port: op, bank, row, data, hold_valid.
  - A request is accepted at a clock edge when any enable is high and full[p]=0.
  - full[p] = hold_valid[p] & ~grant[p]. This is combinational from registered state and the arbiter only; it never depends on same-cycle enables.
  - A port whose held request is granted this cycle may present a new request in the same cycle; no bubble.
- Arbitration (cycle after acceptance):
  - Each bank has an independent rotating-priority arbiter over the ports holding a request to that bank.
  - The search starts at the bank's pointer. On a grant, the pointer moves to winner+1 mod PORTS; with no grant, the pointer is unchanged.
  - At most one grant per bank per cycle. One port can be granted by at most one bank, since it holds one request.
  - Bank lock: the cycle after an add is granted, that bank issues no grant. It performs the write-back instead.
- Bank stage:
  - Granted request drives the bank RAM (registered address/we/data plus port tag and op) at the grant edge.
  - Write: RAM write, no response.
  - Read/add: synchronous RAM read.
  - Add write-back: on the following cycle, row <- old + addend, truncated mod 2^WIDTH; carry discarded.
- Response stage:
  - Read data is routed by port tag into q[p], registered, with valid[p]=1 for one cycle.
  - Latency: valid rises exactly 3 cycles after the acceptance edge when uncontended, plus 1 cycle per lost arbitration or bank-lock cycle.
  - No stall input; consumers must sink every response.
- Ordering: requests to the same bank execute in grant order.
  - A read granted in the cycle after an add to the same row cannot occur, because of the bank lock.
  - A later read observes the sum.
  - Writes do not generate valid.
- Reset (synchronous, active-high):
  - hold_valid=0, all pointers=0, bank-stage valid=0, lock=0, valid=0, q=0, full=0.
  - RAM contents are not cleared.
  - Reset mid-operation discards all in-flight requests and any pending add write-back; no valid is produced for them.
- A request with all enables low is ignored regardless of full.

Decomposition:
- Shared header: log2 function (existing log2.vh); opcode constants OP_RD=0, OP_WR=1, OP_ADD=2 in constants.vh.
- Sub-module rr_arbiter #(PORTS): request vector and pointer in, one-hot grant plus next pointer out; instantiated per bank.
- Banks reuse the existing simple_ram #(WIDTH, BANK_DEPTH), single-port.

Test Plan:
- Reset, then port0 writes 0x55 at addr 0x009, then reads 0x009 -> valid[0] exactly 3 cycles after read acceptance, q[0]=0x55; full stays 0.
- All 8 ports read bank 3 (addrs 0x003, 0x00B, ...) in the same cycle -> grants rotate 0..7, valid pattern one port per cycle, full[p] deasserts in grant order; second burst starts after the last winner.
- Ports 0..7 read distinct banks in the same cycle -> all valid together at latency 3, no full asserted.
- mem[0x010]=0xFFFF_FFFF_FFFF_FFFF; port1 add 1, then port2 read 0x010 one cycle later -> q[1]=all-ones, q[2]=0, port2 delayed 1 cycle by the bank lock.
- Ports 0 and 4 both add 5 to addr 0x020 (initially 10) simultaneously -> q values {10, 15} in grant order; a final read returns 20.
- Assert rst while 4 reads are in flight -> no valid in the following cycles; full=0; a subsequent read returns data written before reset.
